bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It is the stage directly upstream of the seven-segment decoders: it takes a WIDTH-bit unsigned value and produces DIGITS packed BCD nibbles, one nibble per HEX display. It extends the lab's combinational 0–15 comparator/mux split to arbitrary widths, handshaking via start/busy/done.

---
 rtl/bin_to_bcd_seq.sv | 102 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Feeds the seven-segment decoders: one packed BCD nibble per display, units in nibble 0.
module bin_to_bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  CLOCK_50,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg, sreg_nx;
   logic [BW-1:0]    scratch, adj, scratch_nx;
   logic             ovf_acc, ovf_nx;
   logic [CW-1:0]    cnt;
   logic             last;

   // Every digit is corrected from its pre-shift value, all digits in parallel.
   function automatic logic [BW-1:0] add3(input logic [BW-1:0] s);
      logic [BW-1:0] r;
      r = s;
      for (int i = 0; i < DIGITS; i++) begin
         if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   always_comb begin
      adj        = add3(scratch);
      scratch_nx = {adj[BW-2:0], sreg[WIDTH-1]};
      ovf_nx     = ovf_acc | adj[BW-1];
      sreg_nx    = sreg << 1;
      last       = (cnt == CNT_ONE);
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (last)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == SHIFT);

   // Results are published only on the final shift, so bcd never shows partial scratch.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         sreg     <= '0;
         scratch  <= '0;
         ovf_acc  <= 1'b0;
         cnt      <= '0;
         bcd      <= '0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  sreg    <= bin;
                  scratch <= '0;
                  ovf_acc <= 1'b0;
                  cnt     <= CNT_LOAD;
               end
            end
            SHIFT: begin
               sreg    <= sreg_nx;
               scratch <= scratch_nx;
               ovf_acc <= ovf_nx;
               cnt     <= cnt - CNT_ONE;
               if (last) begin
                  bcd      <= scratch_nx;
                  overflow <= ovf_nx;
                  done     <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: 8-bit/3-digit instance plus 4-bit instances with 1 and 2 digits.
module tb_bin_to_bcd_seq;

   typedef struct {
      logic [11:0] bcd;
      logic        ovf;
   } exp_t;

   typedef struct {
      int          bin;
      logic [11:0] bcd;
      logic        ovf;
   } vec8_t;

   typedef struct {
      int          bin;
      logic [3:0]  bcd1;
      logic        ovf1;
      logic [7:0]  bcd2;
      logic        ovf2;
   } vec4_t;

   logic        CLOCK_50 = 1'b0;
   logic        resetn   = 1'b0;
   logic        start8   = 1'b0;
   logic [7:0]  bin8     = '0;
   logic        start4   = 1'b0;
   logic [3:0]  bin4     = '0;

   logic        busy8, done8, ovf8;
   logic [11:0] bcd8;
   logic        busy41, done41, ovf41;
   logic [3:0]  bcd41;
   logic        busy42, done42, ovf42;
   logic [7:0]  bcd42;

   int checks = 0;
   int errors = 0;
   exp_t q8[$];
   exp_t q41[$];
   exp_t q42[$];

   always #5 CLOCK_50 = ~CLOCK_50;

   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u8 (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start8), .bin(bin8),
      .busy(busy8), .done(done8), .bcd(bcd8), .overflow(ovf8));
   bin_to_bcd_seq #(.WIDTH(4), .DIGITS(1)) u41 (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start4), .bin(bin4),
      .busy(busy41), .done(done41), .bcd(bcd41), .overflow(ovf41));
   bin_to_bcd_seq #(.WIDTH(4), .DIGITS(2)) u42 (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start4), .bin(bin4),
      .busy(busy42), .done(done42), .bcd(bcd42), .overflow(ovf42));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t ref_conv(input int v, input int digits);
      exp_t r;
      int   x;
      x     = v;
      r.bcd = '0;
      for (int i = 0; i < digits; i++) begin
         r.bcd[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      r.ovf = (x != 0);
      return r;
   endfunction

   always @(negedge CLOCK_50) begin
      exp_t e;
      if (done8) begin
         if (q8.size() == 0) chk("done8_unexpected", 32'd1, 32'd0);
         else begin
            e = q8.pop_front();
            chk("bcd8", {20'd0, bcd8}, {20'd0, e.bcd});
            chk("ovf8", {31'd0, ovf8}, {31'd0, e.ovf});
         end
      end
      if (done41) begin
         if (q41.size() == 0) chk("done41_unexpected", 32'd1, 32'd0);
         else begin
            e = q41.pop_front();
            chk("bcd41", {28'd0, bcd41}, {28'd0, e.bcd[3:0]});
            chk("ovf41", {31'd0, ovf41}, {31'd0, e.ovf});
         end
      end
      if (done42) begin
         if (q42.size() == 0) chk("done42_unexpected", 32'd1, 32'd0);
         else begin
            e = q42.pop_front();
            chk("bcd42", {24'd0, bcd42}, {24'd0, e.bcd[7:0]});
            chk("ovf42", {31'd0, ovf42}, {31'd0, e.ovf});
         end
      end
   end

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((q8.size() != 0 || q41.size() != 0 || q42.size() != 0) && n < 30) begin
         @(negedge CLOCK_50);
         n++;
      end
      if (q8.size() != 0 || q41.size() != 0 || q42.size() != 0) begin
         chk({name, "_timeout"}, 32'd1, 32'd0);
         q8.delete(); q41.delete(); q42.delete();
      end
   endtask

   task automatic conv8(input int v, input logic [11:0] eb, input logic eo);
      exp_t e;
      @(negedge CLOCK_50);
      e.bcd = eb; e.ovf = eo;
      start8 = 1'b1; bin8 = 8'(v);
      q8.push_back(e);
      @(negedge CLOCK_50);
      start8 = 1'b0;
      wait_drain("conv8");
   endtask

   task automatic conv4(input int v, input exp_t e1, input exp_t e2);
      @(negedge CLOCK_50);
      start4 = 1'b1; bin4 = 4'(v);
      q41.push_back(e1);
      q42.push_back(e2);
      @(negedge CLOCK_50);
      start4 = 1'b0;
      wait_drain("conv4");
   endtask

   initial begin
      vec8_t v8[10];
      vec4_t v4[6];
      exp_t  e, e2;
      int    n;

      v8[0] = '{255, 12'h255, 1'b0};
      v8[1] = '{ 99, 12'h099, 1'b0};
      v8[2] = '{100, 12'h100, 1'b0};
      v8[3] = '{  1, 12'h001, 1'b0};
      v8[4] = '{  9, 12'h009, 1'b0};
      v8[5] = '{ 10, 12'h010, 1'b0};
      v8[6] = '{128, 12'h128, 1'b0};
      v8[7] = '{ 37, 12'h037, 1'b0};
      v8[8] = '{200, 12'h200, 1'b0};
      v8[9] = '{199, 12'h199, 1'b0};
      v4[0] = '{15, 4'h5, 1'b1, 8'h15, 1'b0};
      v4[1] = '{ 9, 4'h9, 1'b0, 8'h09, 1'b0};
      v4[2] = '{10, 4'h0, 1'b1, 8'h10, 1'b0};
      v4[3] = '{ 0, 4'h0, 1'b0, 8'h00, 1'b0};
      v4[4] = '{ 7, 4'h7, 1'b0, 8'h07, 1'b0};
      v4[5] = '{12, 4'h2, 1'b1, 8'h12, 1'b0};

      repeat (3) @(negedge CLOCK_50);
      chk("rst_busy", {31'd0, busy8}, 32'd0);
      chk("rst_done", {31'd0, done8}, 32'd0);
      chk("rst_bcd",  {20'd0, bcd8},  32'd0);
      chk("rst_ovf",  {31'd0, ovf8},  32'd0);
      resetn = 1'b1;
      @(negedge CLOCK_50);

      // latency: start in cycle 0, busy cycles 1..8, done cycle 9
      e.bcd = 12'h000; e.ovf = 1'b0;
      start8 = 1'b1; bin8 = 8'd0; q8.push_back(e);
      @(negedge CLOCK_50);
      start8 = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("lat_busy_c%0d", i), {31'd0, busy8}, 32'd1);
         chk($sformatf("lat_done_c%0d", i), {31'd0, done8}, 32'd0);
         @(negedge CLOCK_50);
      end
      chk("lat_done_c9", {31'd0, done8}, 32'd1);
      chk("lat_busy_c9", {31'd0, busy8}, 32'd0);
      @(negedge CLOCK_50);
      chk("lat_done_c10", {31'd0, done8}, 32'd0);
      wait_drain("lat");

      for (int i = 0; i < 10; i++) conv8(v8[i].bin, v8[i].bcd, v8[i].ovf);
      for (int v = 0; v < 256; v++) begin
         e = ref_conv(v, 3);
         conv8(v, e.bcd, e.ovf);
      end

      // back-to-back: start accepted in the done cycle
      e.bcd = 12'h037; e.ovf = 1'b0;
      @(negedge CLOCK_50);
      start8 = 1'b1; bin8 = 8'd37; q8.push_back(e);
      @(negedge CLOCK_50);
      start8 = 1'b0;
      n = 0;
      while (!done8 && n < 20) begin @(negedge CLOCK_50); n++; end
      chk("b2b_first_done", {31'd0, done8}, 32'd1);
      e.bcd = 12'h200;
      start8 = 1'b1; bin8 = 8'd200; q8.push_back(e);
      @(negedge CLOCK_50);
      start8 = 1'b0;
      n = 1;
      while (!done8 && n < 20) begin @(negedge CLOCK_50); n++; end
      chk("b2b_gap", n, 32'd9);
      wait_drain("b2b");

      // start and bin activity while busy must be ignored
      e.bcd = 12'h123; e.ovf = 1'b0;
      @(negedge CLOCK_50);
      start8 = 1'b1; bin8 = 8'd123; q8.push_back(e);
      @(negedge CLOCK_50);
      start8 = 1'b0;
      @(negedge CLOCK_50);
      start8 = 1'b1; bin8 = 8'd77;
      repeat (3) @(negedge CLOCK_50);
      start8 = 1'b0; bin8 = 8'd5;
      wait_drain("busy_ign");
      repeat (12) @(negedge CLOCK_50);
      chk("busy_ign_no_extra", {31'd0, busy8}, 32'd0);
      chk("busy_ign_hold", {20'd0, bcd8}, 32'h123);

      // asynchronous reset in cycle 4 of converting 255: no done may follow
      @(negedge CLOCK_50);
      start8 = 1'b1; bin8 = 8'd255;
      @(negedge CLOCK_50);
      start8 = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      chk("mid_busy_before", {31'd0, busy8}, 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_busy", {31'd0, busy8}, 32'd0);
      chk("mid_rst_done", {31'd0, done8}, 32'd0);
      chk("mid_rst_bcd",  {20'd0, bcd8},  32'd0);
      @(negedge CLOCK_50);
      resetn = 1'b1;
      repeat (15) @(negedge CLOCK_50);
      chk("mid_rst_idle", {31'd0, busy8}, 32'd0);
      conv8(42, 12'h042, 1'b0);

      for (int i = 0; i < 6; i++) begin
         e.bcd  = {8'd0, v4[i].bcd1}; e.ovf  = v4[i].ovf1;
         e2.bcd = {4'd0, v4[i].bcd2}; e2.ovf = v4[i].ovf2;
         conv4(v4[i].bin, e, e2);
      end
      for (int v = 0; v < 16; v++) conv4(v, ref_conv(v, 1), ref_conv(v, 2));

      repeat (3) @(negedge CLOCK_50);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
